execute_muldiv: RTL and testbench

- Next-generation EX stage of the 5-stage MIPS pipeline, between the ID/EX and EX/MEM registers.
- Adds forwarding in-stage, which ignores register 0, and registers the EX/MEM outputs.
- Adds an iterative multiply/divide engine with HI/LO registers and a stall handshake toward the hazard logic.
- Ordinary ALU instructions proceed in parallel while the engine is busy.

---
 rtl/execute_muldiv_if.sv | 53 +++++
 rtl/execute_muldiv.sv | 248 ++++++++++++++++++++++++
 tb/tb_execute_muldiv.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_if.sv
// Port bundle of the execute_muldiv EX stage: ID/EX operands and control in,
// forwarding sources, stall handshake and registered EX/MEM results out.
interface execute_muldiv_if #(
  parameter int len          = 32,
  parameter int NB           = $clog2(len),
  parameter int len_exec_bus = 12,
  parameter int len_mem_bus  = 9,
  parameter int len_wb_bus   = 2
);
  logic [len-1:0]          in_pc_branch;
  logic [len-1:0]          in_reg1;
  logic [len-1:0]          in_reg2;
  logic [len-1:0]          in_sign_extend;
  logic [NB-1:0]           in_rs;
  logic [NB-1:0]           in_rt;
  logic [NB-1:0]           in_rd;
  logic [NB-1:0]           in_shamt;
  logic [len_exec_bus-1:0] execute_bus;
  logic [len_mem_bus-1:0]  memory_bus;
  logic [len_wb_bus-1:0]   writeBack_bus;
  logic                    register_write_3_4;
  logic                    register_write_4_5;
  logic [NB-1:0]           rd_3_4;
  logic [NB-1:0]           rd_4_5;
  logic [len-1:0]          in_mem_forw;
  logic [len-1:0]          in_wb_forw;
  logic                    in_flush;
  logic                    out_stall;
  logic                    md_busy;
  logic [len-1:0]          out_pc_branch;
  logic [len-1:0]          out_alu;
  logic [len-1:0]          out_reg2;
  logic                    zero_flag;
  logic [NB-1:0]           out_write_reg;
  logic [len_mem_bus-1:0]  memory_bus_out;
  logic [len_wb_bus-1:0]   writeBack_bus_out;

  modport master (
    output in_pc_branch, in_reg1, in_reg2, in_sign_extend, in_rs, in_rt, in_rd,
           in_shamt, execute_bus, memory_bus, writeBack_bus, register_write_3_4,
           register_write_4_5, rd_3_4, rd_4_5, in_mem_forw, in_wb_forw, in_flush,
    input  out_stall, md_busy, out_pc_branch, out_alu, out_reg2, zero_flag,
           out_write_reg, memory_bus_out, writeBack_bus_out
  );

  modport slave (
    input  in_pc_branch, in_reg1, in_reg2, in_sign_extend, in_rs, in_rt, in_rd,
           in_shamt, execute_bus, memory_bus, writeBack_bus, register_write_3_4,
           register_write_4_5, rd_3_4, rd_4_5, in_mem_forw, in_wb_forw, in_flush,
    output out_stall, md_busy, out_pc_branch, out_alu, out_reg2, zero_flag,
           out_write_reg, memory_bus_out, writeBack_bus_out
  );
endinterface

// File: rtl/execute_muldiv.sv
// MIPS EX stage with in-stage forwarding, registered EX/MEM outputs and an iterative
// MULTU/DIVU engine with HI/LO. Define SIGNED_MD_EN to add signed MULT/DIV (md_op 101/110).
module execute_muldiv #(
  parameter int len          = 32,
  parameter int NB           = $clog2(len),
  parameter int len_exec_bus = 12,
  parameter int len_mem_bus  = 9,
  parameter int len_wb_bus   = 2
) (
  input  logic             clk,
  input  logic             reset,
  execute_muldiv_if.slave  bus
);
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_MFHI  = 3'b011;
  localparam logic [2:0] MD_MFLO  = 3'b100;
`ifdef SIGNED_MD_EN
  localparam logic [2:0] MD_MULT  = 3'b101;
  localparam logic [2:0] MD_DIV   = 3'b110;
`endif
  localparam logic [NB:0] CNT_LEN = (NB+1)'(len);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIX = 2'd2} md_state_e;

  function automatic logic [len-1:0] fwd_pick(
    input logic [NB-1:0] src, input logic [len-1:0] rf_val,
    input logic wr_mem, input logic [NB-1:0] rd_mem, input logic [len-1:0] d_mem,
    input logic wr_wb, input logic [NB-1:0] rd_wb, input logic [len-1:0] d_wb);
    logic [len-1:0] v;
    if (wr_mem && (rd_mem == src) && (src != {NB{1'b0}})) v = d_mem;
    else if (wr_wb && (rd_wb == src) && (src != {NB{1'b0}})) v = d_wb;
    else v = rf_val;
    return v;
  endfunction

  md_state_e      state_r, state_nxt_s;
  logic [len-1:0] fwd_a_s, fwd_b_s, op_a_s, op_b_s, alu_res_s, result_s;
  logic [len-1:0] mag_a_s, mag_b_s;
  logic [3:0]     alu_op_s;
  logic [2:0]     md_op_s;
  logic           is_mul_s, is_div_s, is_signed_s, md_use_s;
  logic           out_stall_s, bubble_s, start_s, last_step_s, neg_a_s, neg_b_s;
  logic [len-1:0] hi_r, lo_r, eng_hi_r, eng_lo_r, eng_op_r;
  logic [NB:0]    cnt_r;
  logic           eng_mul_r, md_signed_r, neg_q_r, neg_r_r, md_busy_r;
  logic [len:0]   mul_sum_s, div_shift_s, div_diff_s;
  logic [len-1:0] step_hi_s, step_lo_s, fix_hi_s, fix_lo_s;
  logic [len-1:0] pc_r, alu_r, reg2_r;
  logic           zero_r;
  logic [NB-1:0]  wr_r;
  logic [len_mem_bus-1:0] mem_r;
  logic [len_wb_bus-1:0]  wb_r;
  logic           unused_ok_s;

  assign unused_ok_s = ^{bus.execute_bus[5:4], div_diff_s[len]};

  // Operand forwarding and ALU operand muxes
  always_comb begin
    fwd_a_s = fwd_pick(bus.in_rs, bus.in_reg1, bus.register_write_3_4, bus.rd_3_4,
                       bus.in_mem_forw, bus.register_write_4_5, bus.rd_4_5, bus.in_wb_forw);
    fwd_b_s = fwd_pick(bus.in_rt, bus.in_reg2, bus.register_write_3_4, bus.rd_3_4,
                       bus.in_mem_forw, bus.register_write_4_5, bus.rd_4_5, bus.in_wb_forw);
    if (bus.execute_bus[7]) op_a_s = {{(len-NB){1'b0}}, bus.in_shamt};
    else op_a_s = fwd_a_s;
    if (bus.execute_bus[6]) op_b_s = bus.in_sign_extend;
    else op_b_s = fwd_b_s;
    alu_op_s = bus.execute_bus[3:0];
  end

  // ALU; shifts move operand B by the low bits of operand A
  always_comb begin
    alu_res_s = {len{1'b0}};
    case (alu_op_s)
      4'd0:    alu_res_s = op_a_s + op_b_s;
      4'd1:    alu_res_s = op_a_s - op_b_s;
      4'd2:    alu_res_s = op_a_s & op_b_s;
      4'd3:    alu_res_s = op_a_s | op_b_s;
      4'd4:    alu_res_s = op_a_s ^ op_b_s;
      4'd5:    alu_res_s = ~(op_a_s | op_b_s);
      4'd6:    alu_res_s = {{(len-1){1'b0}}, ($signed(op_a_s) < $signed(op_b_s))};
      4'd7:    alu_res_s = {{(len-1){1'b0}}, (op_a_s < op_b_s)};
      4'd8:    alu_res_s = op_b_s << op_a_s[NB-1:0];
      4'd9:    alu_res_s = op_b_s >> op_a_s[NB-1:0];
      4'd10:   alu_res_s = $unsigned($signed(op_b_s) >>> op_a_s[NB-1:0]);
      4'd11:   alu_res_s = op_b_s << 5'd16;
      default: alu_res_s = {len{1'b0}};
    endcase
  end

  // md_op decode, stall, bubble and engine-start qualification
  always_comb begin
    md_op_s     = bus.execute_bus[11:9];
    is_mul_s    = 1'b0;
    is_div_s    = 1'b0;
    is_signed_s = 1'b0;
    md_use_s    = 1'b0;
    case (md_op_s)
      MD_MULTU: begin is_mul_s = 1'b1; md_use_s = 1'b1; end
      MD_DIVU:  begin is_div_s = 1'b1; md_use_s = 1'b1; end
      MD_MFHI:  md_use_s = 1'b1;
      MD_MFLO:  md_use_s = 1'b1;
`ifdef SIGNED_MD_EN
      MD_MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; md_use_s = 1'b1; end
      MD_DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; md_use_s = 1'b1; end
`endif
      default:  md_use_s = 1'b0;
    endcase
    out_stall_s = md_busy_r & md_use_s;
    bubble_s    = bus.in_flush | out_stall_s;
    start_s     = (is_mul_s | is_div_s) & ~bubble_s;
    last_step_s = (cnt_r == {{NB{1'b0}}, 1'b1});
    if (md_op_s == MD_MFHI) result_s = hi_r;
    else if (md_op_s == MD_MFLO) result_s = lo_r;
    else result_s = alu_res_s;
  end

  // Signed ops run the unsigned engine on magnitudes
  always_comb begin
    neg_a_s = is_signed_s & fwd_a_s[len-1];
    neg_b_s = is_signed_s & fwd_b_s[len-1];
    if (neg_a_s) mag_a_s = -fwd_a_s;
    else mag_a_s = fwd_a_s;
    if (neg_b_s) mag_b_s = -fwd_b_s;
    else mag_b_s = fwd_b_s;
  end

  // One shift-add (multiply) or restoring-subtract (divide) step
  always_comb begin
    mul_sum_s   = {1'b0, eng_hi_r} + (eng_lo_r[0] ? {1'b0, eng_op_r} : {(len+1){1'b0}});
    div_shift_s = {eng_hi_r, eng_lo_r[len-1]};
    div_diff_s  = div_shift_s - {1'b0, eng_op_r};
    if (eng_mul_r) begin
      step_hi_s = mul_sum_s[len:1];
      step_lo_s = {mul_sum_s[0], eng_lo_r[len-1:1]};
    end else if (div_shift_s >= {1'b0, eng_op_r}) begin
      step_hi_s = div_diff_s[len-1:0];
      step_lo_s = {eng_lo_r[len-2:0], 1'b1};
    end else begin
      step_hi_s = div_shift_s[len-1:0];
      step_lo_s = {eng_lo_r[len-2:0], 1'b0};
    end
  end

  // Sign fix-up of the unsigned engine result
  always_comb begin
    if (eng_mul_r) begin
      if (neg_q_r) {fix_hi_s, fix_lo_s} = -{eng_hi_r, eng_lo_r};
      else {fix_hi_s, fix_lo_s} = {eng_hi_r, eng_lo_r};
    end else begin
      fix_lo_s = neg_q_r ? -eng_lo_r : eng_lo_r;
      fix_hi_s = neg_r_r ? -eng_hi_r : eng_hi_r;
    end
  end

  // Engine state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else state_r <= state_nxt_s;
  end

  // Engine next state: IDLE -> RUN (len steps) -> optional FIX -> IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_RUN;
        else state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_step_s) state_nxt_s = md_signed_r ? ST_FIX : ST_IDLE;
        else state_nxt_s = ST_RUN;
      end
      ST_FIX:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Engine datapath and HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= {len{1'b0}};  lo_r <= {len{1'b0}};
      eng_hi_r <= {len{1'b0}};  eng_lo_r <= {len{1'b0}};  eng_op_r <= {len{1'b0}};
      cnt_r <= {(NB+1){1'b0}};
      eng_mul_r <= 1'b0;  md_signed_r <= 1'b0;  neg_q_r <= 1'b0;  neg_r_r <= 1'b0;
      md_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            eng_mul_r   <= is_mul_s;
            md_signed_r <= is_signed_s;
            neg_q_r     <= neg_a_s ^ neg_b_s;
            neg_r_r     <= neg_a_s;
            eng_hi_r    <= {len{1'b0}};
            eng_op_r    <= is_mul_s ? mag_a_s : mag_b_s;
            eng_lo_r    <= is_mul_s ? mag_b_s : mag_a_s;
            cnt_r       <= CNT_LEN;
          end
        end
        ST_RUN: begin
          eng_hi_r <= step_hi_s;
          eng_lo_r <= step_lo_s;
          cnt_r    <= cnt_r - {{NB{1'b0}}, 1'b1};
          if (last_step_s && !md_signed_r) begin
            hi_r <= step_hi_s;
            lo_r <= step_lo_s;
          end
        end
`ifdef SIGNED_MD_EN
        ST_FIX: begin
          hi_r <= fix_hi_s;
          lo_r <= fix_lo_s;
        end
`endif
        default: cnt_r <= cnt_r;
      endcase
      md_busy_r <= (state_nxt_s != ST_IDLE);
    end
  end

  // EX/MEM pipeline register; a flush or stall loads an all-zero bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bubble_s) begin
      pc_r <= {len{1'b0}};  alu_r <= {len{1'b0}};  reg2_r <= {len{1'b0}};
      zero_r <= 1'b0;  wr_r <= {NB{1'b0}};
      mem_r <= {len_mem_bus{1'b0}};  wb_r <= {len_wb_bus{1'b0}};
    end else begin
      pc_r   <= bus.in_pc_branch + (bus.in_sign_extend << 2'd2);
      alu_r  <= result_s;
      reg2_r <= fwd_b_s;
      zero_r <= (alu_res_s == {len{1'b0}});
      wr_r   <= bus.execute_bus[8] ? bus.in_rd : bus.in_rt;
      mem_r  <= bus.memory_bus;
      wb_r   <= bus.writeBack_bus;
    end
  end

  assign bus.out_stall         = out_stall_s;
  assign bus.md_busy           = md_busy_r;
  assign bus.out_pc_branch     = pc_r;
  assign bus.out_alu           = alu_r;
  assign bus.out_reg2          = reg2_r;
  assign bus.zero_flag         = zero_r;
  assign bus.out_write_reg     = wr_r;
  assign bus.memory_bus_out    = mem_r;
  assign bus.writeBack_bus_out = wb_r;
endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed and randomized instructions
// compared against an arithmetic reference model of the EX stage and HI/LO unit.
module tb_execute_muldiv;
  localparam int LEN = 32;
  logic clk, reset;
  int checks, failures, busy_cnt, n;
  logic [31:0] hi_m, lo_m, p_hi, p_lo;

  execute_muldiv_if bus ();
  execute_muldiv dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return b << a[4:0];
      4'd9: return b >> a[4:0];
      4'd10: return 32'($signed(b) >>> a[4:0]);
      4'd11: return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(input logic [4:0] src, input logic [31:0] rf);
    if (src == 5'd0) return rf;
    if (bus.register_write_3_4 && bus.rd_3_4 == src) return bus.in_mem_forw;
    if (bus.register_write_4_5 && bus.rd_4_5 == src) return bus.in_wb_forw;
    return rf;
  endfunction

  function automatic bit is_start_op(input logic [2:0] m);
    bit s;
    s = (m == 3'd1) || (m == 3'd2);
`ifdef SIGNED_MD_EN
    if (m == 3'd5 || m == 3'd6) s = 1'b1;
`endif
    return s;
  endfunction

  function automatic bit is_md_op(input logic [2:0] m);
    return is_start_op(m) || (m == 3'd3) || (m == 3'd4);
  endfunction

  task automatic md_launch(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    busy_cnt = LEN;
    case (m)
      3'd1: begin prod = {32'd0, a} * {32'd0, b}; p_hi = prod[63:32]; p_lo = prod[31:0]; end
      3'd2: begin
        if (b == 32'd0) begin p_lo = 32'hFFFF_FFFF; p_hi = a; end
        else begin p_lo = a / b; p_hi = a % b; end
      end
`ifdef SIGNED_MD_EN
      3'd5: begin
        prod = 64'(longint'($signed(a)) * longint'($signed(b)));
        p_hi = prod[63:32]; p_lo = prod[31:0]; busy_cnt = LEN + 1;
      end
      3'd6: begin
        p_lo = 32'($signed(a) / $signed(b)); p_hi = 32'($signed(a) % $signed(b)); busy_cnt = LEN + 1;
      end
`endif
      default: busy_cnt = 0;
    endcase
  endtask

  // one clock of the stage: check stall now, registered results after the edge
  task automatic step(output bit stalled);
    logic [2:0] m;
    logic [31:0] a, b, oa, ob, r, exp_res, pc;
    logic [4:0] wr;
    logic [8:0] mb;
    logic [1:0] wbv;
    logic exp_stall, bub;
    #1;
    m = bus.execute_bus[11:9];
    exp_stall = (busy_cnt > 0) && is_md_op(m);
    stalled = bus.out_stall;
    chk("out_stall", 32'(bus.out_stall), 32'(exp_stall));
    a = fwd_ref(bus.in_rs, bus.in_reg1);
    b = fwd_ref(bus.in_rt, bus.in_reg2);
    oa = bus.execute_bus[7] ? {27'd0, bus.in_shamt} : a;
    ob = bus.execute_bus[6] ? bus.in_sign_extend : b;
    r = alu_ref(bus.execute_bus[3:0], oa, ob);
    exp_res = (m == 3'd3) ? hi_m : ((m == 3'd4) ? lo_m : r);
    pc = bus.in_pc_branch + (bus.in_sign_extend << 2);
    wr = bus.execute_bus[8] ? bus.in_rd : bus.in_rt;
    mb = bus.memory_bus;
    wbv = bus.writeBack_bus;
    bub = bus.in_flush || exp_stall;
    @(posedge clk);
    #1;
    if (bub) begin
      chk("bubble_mem", 32'(bus.memory_bus_out), 32'd0);
      chk("bubble_wb", 32'(bus.writeBack_bus_out), 32'd0);
    end else begin
      chk("out_alu", bus.out_alu, exp_res);
      chk("out_reg2", bus.out_reg2, b);
      chk("out_pc_branch", bus.out_pc_branch, pc);
      chk("zero_flag", 32'(bus.zero_flag), 32'(r == 32'd0));
      chk("out_write_reg", 32'(bus.out_write_reg), 32'(wr));
      chk("memory_bus_out", 32'(bus.memory_bus_out), 32'(mb));
      chk("writeBack_bus_out", 32'(bus.writeBack_bus_out), 32'(wbv));
    end
    if (!bub && is_start_op(m)) md_launch(m, a, b);
    else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin hi_m = p_hi; lo_m = p_lo; end
    end
    chk("md_busy", 32'(bus.md_busy), 32'(busy_cnt > 0));
    @(negedge clk);
  endtask

  // hold the current instruction until it is accepted; returns stall cycles
  task automatic go(output int stalls);
    bit st;
    stalls = 0;
    for (int i = 0; i < 80; i++) begin
      step(st);
      if (!st) return;
      stalls++;
    end
    chk("hold_timeout", 32'(stalls), 32'd0);
  endtask

  task automatic set_instr(input logic [3:0] aop, input logic [2:0] mop,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [4:0] rs, input logic [4:0] rt);
    bus.execute_bus = {mop, 1'b1, 1'b0, 1'b0, 2'b00, aop};
    bus.in_reg1 = r1;  bus.in_reg2 = r2;  bus.in_rs = rs;  bus.in_rt = rt;
    bus.in_rd = 5'($urandom);  bus.in_shamt = 5'($urandom);
    bus.in_sign_extend = $urandom;  bus.in_pc_branch = $urandom;
    bus.memory_bus = 9'($urandom);  bus.writeBack_bus = 2'($urandom);
    bus.register_write_3_4 = 1'b0;  bus.register_write_4_5 = 1'b0;
    bus.rd_3_4 = 5'($urandom);  bus.rd_4_5 = 5'($urandom);
    bus.in_mem_forw = $urandom;  bus.in_wb_forw = $urandom;
    bus.in_flush = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pc"}, bus.out_pc_branch, 32'd0);
    chk({tag, "_alu"}, bus.out_alu, 32'd0);
    chk({tag, "_reg2"}, bus.out_reg2, 32'd0);
    chk({tag, "_zero"}, 32'(bus.zero_flag), 32'd0);
    chk({tag, "_wr"}, 32'(bus.out_write_reg), 32'd0);
    chk({tag, "_mem"}, 32'(bus.memory_bus_out), 32'd0);
    chk({tag, "_wb"}, 32'(bus.writeBack_bus_out), 32'd0);
    chk({tag, "_busy"}, 32'(bus.md_busy), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; busy_cnt = 0; hi_m = 32'd0; lo_m = 32'd0;
    p_hi = 32'd0; p_lo = 32'd0;
    reset = 1'b0;
    set_instr(4'd0, 3'd0, 32'd1, 32'd2, 5'd1, 5'd2);
    repeat (2) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;

    // MULTU 0xFFFFFFFF * 2, MFHI right behind it, then MFLO
    set_instr(4'd0, 3'd1, 32'hFFFF_FFFF, 32'd2, 5'd1, 5'd2); go(n);
    chk("multu_issue_stalls", 32'(n), 32'd0);
    set_instr(4'd0, 3'd3, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("mfhi_stalls", 32'(n), 32'd32);
    chk("mfhi_val", bus.out_alu, 32'h0000_0001);
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("mflo_stalls", 32'(n), 32'd0);
    chk("mflo_val", bus.out_alu, 32'hFFFF_FFFE);

    // DIVU 100/7 with independent ADDs overlapping the engine
    set_instr(4'd0, 3'd2, 32'd100, 32'd7, 5'd4, 5'd5); go(n);
    for (int i = 0; i < 3; i++) begin
      set_instr(4'd0, 3'd0, $urandom, $urandom, 5'd6, 5'd7); go(n);
      chk("add_during_div_stalls", 32'(n), 32'd0);
      chk("add_during_div_busy", 32'(bus.md_busy), 32'd1);
    end
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("divu_lo", bus.out_alu, 32'd14);
    set_instr(4'd0, 3'd3, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("divu_hi", bus.out_alu, 32'd2);

    // DIVU by zero
    set_instr(4'd0, 3'd2, 32'd5, 32'd0, 5'd4, 5'd5); go(n);
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("div0_lo", bus.out_alu, 32'hFFFF_FFFF);
    set_instr(4'd0, 3'd3, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("div0_hi", bus.out_alu, 32'd5);

    // forwarding: MEM beats WB; register 0 never forwards
    set_instr(4'd3, 3'd0, 32'h0000_AAAA, 32'd0, 5'd3, 5'd0);
    bus.register_write_3_4 = 1'b1; bus.rd_3_4 = 5'd3; bus.in_mem_forw = 32'h1111_2222;
    bus.register_write_4_5 = 1'b1; bus.rd_4_5 = 5'd3; bus.in_wb_forw = 32'h3333_4444;
    go(n);
    chk("fwd_mem_prio", bus.out_alu, 32'h1111_2222);
    set_instr(4'd3, 3'd0, 32'h0000_AAAA, 32'd0, 5'd3, 5'd0);
    bus.register_write_3_4 = 1'b1; bus.rd_3_4 = 5'd9; bus.in_mem_forw = 32'h1111_2222;
    bus.register_write_4_5 = 1'b1; bus.rd_4_5 = 5'd3; bus.in_wb_forw = 32'h3333_4444;
    go(n);
    chk("fwd_wb", bus.out_alu, 32'h3333_4444);
    set_instr(4'd3, 3'd0, 32'h0000_AAAA, 32'd0, 5'd0, 5'd0);
    bus.register_write_3_4 = 1'b1; bus.rd_3_4 = 5'd0; bus.in_mem_forw = 32'h1111_2222;
    bus.register_write_4_5 = 1'b1; bus.rd_4_5 = 5'd0; bus.in_wb_forw = 32'h3333_4444;
    go(n);
    chk("fwd_r0", bus.out_alu, 32'h0000_AAAA);

    // flushed MULTU: no engine start, bubble out
    set_instr(4'd0, 3'd1, 32'd3, 32'd4, 5'd1, 5'd2);
    bus.in_flush = 1'b1; bus.memory_bus = 9'h1FF; bus.writeBack_bus = 2'b11;
    go(n);
    chk("flush_busy", 32'(bus.md_busy), 32'd0);
    chk("flush_mem", 32'(bus.memory_bus_out), 32'd0);
    chk("flush_wb", 32'(bus.writeBack_bus_out), 32'd0);

`ifdef SIGNED_MD_EN
    set_instr(4'd0, 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd1, 5'd2); go(n);
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("div_s_stalls", 32'(n), 32'd33);
    chk("div_s_lo", bus.out_alu, 32'hFFFF_FFFD);
    set_instr(4'd0, 3'd3, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("div_s_hi", bus.out_alu, 32'hFFFF_FFFF);
    set_instr(4'd0, 3'd5, 32'hFFFF_FFFD, 32'd5, 5'd1, 5'd2); go(n);
    set_instr(4'd0, 3'd3, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("mult_s_hi", bus.out_alu, 32'hFFFF_FFFF);
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("mult_s_lo", bus.out_alu, 32'hFFFF_FFF1);
`else
    set_instr(4'd0, 3'd1, 32'd9, 32'd9, 5'd1, 5'd2); go(n);
    set_instr(4'd0, 3'd6, 32'd1, 32'd2, 5'd1, 5'd2); go(n);
    chk("op110_busy_no_stall", 32'(n), 32'd0);
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("mflo_81", bus.out_alu, 32'd81);
    set_instr(4'd0, 3'd6, 32'd7, 32'd2, 5'd1, 5'd2); go(n);
    chk("op110_no_start", 32'(bus.md_busy), 32'd0);
`endif

    // random ALU traffic with forwarding and flushes
    for (int i = 0; i < 40; i++) begin
      set_instr(4'($urandom), ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7, $urandom, $urandom,
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      bus.execute_bus[8:6] = 3'($urandom);
      bus.register_write_3_4 = 1'($urandom); bus.rd_3_4 = 5'($urandom_range(0, 3));
      bus.register_write_4_5 = 1'($urandom); bus.rd_4_5 = 5'($urandom_range(0, 3));
      bus.in_flush = ($urandom_range(0, 7) == 0);
      go(n);
    end

    // random MULTU/DIVU with overlapping ALU ops, then read back HI/LO
    for (int i = 0; i < 8; i++) begin
      set_instr(4'd0, 3'($urandom_range(1, 2)), $urandom,
                (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom, 5'd1, 5'd2);
      go(n);
      repeat ($urandom_range(0, 4)) begin
        set_instr(4'($urandom), 3'd0, $urandom, $urandom, 5'd3, 5'd4); go(n);
      end
      set_instr(4'd0, 3'd3, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
      set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    end

    // reset in the middle of a MULTU
    set_instr(4'd0, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd1, 5'd2); go(n);
    repeat (10) begin
      set_instr(4'd0, 3'd0, $urandom, $urandom, 5'd3, 5'd4); go(n);
    end
    reset = 1'b0;
    #1;
    check_zero("midop_reset");
    busy_cnt = 0; hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    set_instr(4'd0, 3'd4, 32'd0, 32'd0, 5'd0, 5'd0); go(n);
    chk("mflo_after_reset", bus.out_alu, 32'd0);
    chk("mflo_after_reset_stalls", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
